// File: rtl/fpu_mantissa_normalizer_if.sv
// Handshake bundle for the mantissa normalizer: operand in, normalized result out.
// slave = the normalizer's view, master = the surrounding pipeline's view.
interface fpu_mantissa_normalizer_if #(
  parameter int WIDTH     = 64,
  parameter int EXP_WIDTH = 15,
  parameter int SHW       = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [EXP_WIDTH-1:0] in_exp;
  logic [WIDTH-1:0]     in_mant;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic [EXP_WIDTH-1:0] out_exp;
  logic [WIDTH-1:0]     out_mant;
  logic [SHW-1:0]       out_shift;
  logic                 out_zero;
  logic                 out_denorm;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_shift, out_zero, out_denorm
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_shift, out_zero, out_denorm
  );
endinterface

// File: rtl/fpu_mantissa_normalizer.sv
// Extended-precision mantissa normalizer: counts leading zeros, shifts left, lowers exponent.
// Single-entry, 4-state multicycle unit; result held until downstream takes it.
module fpu_mantissa_normalizer #(
  parameter int WIDTH     = 64,
  parameter int EXP_WIDTH = 15,
  parameter int SHW       = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  fpu_mantissa_normalizer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, SHIFT, DONE} state_e;

  state_e               state_q, state_d;
  logic                 sign_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     mant_q;
  logic [SHW-1:0]       shamt_q;
  logic                 zero_q;
  logic                 denorm_q;

  logic                 out_valid_q;
  logic                 out_sign_q;
  logic [EXP_WIDTH-1:0] out_exp_q;
  logic [WIDTH-1:0]     out_mant_q;
  logic [SHW-1:0]       out_shift_q;
  logic                 out_zero_q;
  logic                 out_denorm_q;

  logic                 in_ready;
  logic                 accept;
  logic                 release_out;

  logic [SHW-1:0]       lzc;
  logic [EXP_WIDTH-1:0] lzc_ext;
  logic                 floor_hit;
  logic [SHW-1:0]       shamt_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = COUNT;
      COUNT:                      state_d = SHIFT;
      SHIFT:                      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready    = (state_q == IDLE);
    accept      = in_ready && bus.in_valid;
    release_out = (state_q == DONE) && out_valid_q && bus.out_ready;
  end

  // Last set bit scanned upward wins, so lzc ends at the most significant one.
  always_comb begin
    lzc = SHW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (mant_q[i]) lzc = SHW'(WIDTH - 1 - i);
    end
  end

  // Clamp the shift so the exponent stops at zero instead of wrapping.
  assign lzc_ext   = {{(EXP_WIDTH-SHW){1'b0}}, lzc};
  assign floor_hit = (lzc_ext > exp_q);
  assign shamt_c   = floor_hit ? exp_q[SHW-1:0] : lzc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_q       <= 1'b0;
      exp_q        <= '0;
      mant_q       <= '0;
      shamt_q      <= '0;
      zero_q       <= 1'b0;
      denorm_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_exp_q    <= '0;
      out_mant_q   <= '0;
      out_shift_q  <= '0;
      out_zero_q   <= 1'b0;
      out_denorm_q <= 1'b0;
    end else begin
      if (accept) begin
        sign_q <= bus.in_sign;
        exp_q  <= bus.in_exp;
        mant_q <= bus.in_mant;
      end
      if (state_q == COUNT) begin
        shamt_q  <= shamt_c;
        zero_q   <= (mant_q == '0);
        denorm_q <= (mant_q != '0) && floor_hit;
      end
      if (state_q == SHIFT) begin
        out_valid_q  <= 1'b1;
        out_sign_q   <= sign_q;
        out_zero_q   <= zero_q;
        out_denorm_q <= denorm_q;
        out_mant_q   <= zero_q ? '0 : (mant_q << shamt_q);
        out_exp_q    <= zero_q ? '0 : (exp_q - EXP_WIDTH'(shamt_q));
        out_shift_q  <= zero_q ? '0 : shamt_q;
      end
      if (release_out) out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sign   = out_sign_q;
  assign bus.out_exp    = out_exp_q;
  assign bus.out_mant   = out_mant_q;
  assign bus.out_shift  = out_shift_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_denorm = out_denorm_q;

endmodule

// File: tb/tb_fpu_mantissa_normalizer.sv
// Directed bench for fpu_mantissa_normalizer with hand-computed expected results.
module tb_fpu_mantissa_normalizer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  fpu_mantissa_normalizer_if #(.WIDTH(64), .EXP_WIDTH(15), .SHW(7)) bus ();

  fpu_mantissa_normalizer #(.WIDTH(64), .EXP_WIDTH(15), .SHW(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_result(input string pfx, input logic s, input logic [14:0] e,
                              input logic [63:0] m, input logic [6:0] sh,
                              input logic z, input logic dn);
    check({pfx, ".sign"},   64'(bus.out_sign),   64'(s));
    check({pfx, ".exp"},    64'(bus.out_exp),    64'(e));
    check({pfx, ".mant"},   bus.out_mant,        m);
    check({pfx, ".shift"},  64'(bus.out_shift),  64'(sh));
    check({pfx, ".zero"},   64'(bus.out_zero),   64'(z));
    check({pfx, ".denorm"}, 64'(bus.out_denorm), 64'(dn));
  endtask

  // Presents an operand, lets it be accepted and waits for out_valid.
  // lat counts edges from the accept edge (inclusive) to the one raising out_valid.
  task automatic send(input logic s, input logic [14:0] e, input logic [63:0] m, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic drain(input string pfx);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({pfx, ".vld_drop"}, 64'(bus.out_valid), 64'd0);
    check({pfx, ".rdy_back"}, 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] held_mant;
    n_checks = 0;
    n_errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_result("rst", 1'b0, 15'h0, 64'h0, 7'd0, 1'b0, 1'b0);
    check("rst.vld", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.rdy", 64'(bus.in_ready), 64'd1);

    // 1: lowest bit only, sign set
    send(1'b1, 15'h3FFF, 64'h0000_0000_0000_0001, lat);
    check("t1.lat", 64'(lat), 64'd3);
    @(negedge clk);
    check_result("t1", 1'b1, 15'h3FC0, 64'h8000_0000_0000_0000, 7'd63, 1'b0, 1'b0);
    drain("t1");

    // 2: already normalized
    send(1'b0, 15'h4000, 64'h8000_0000_0000_0000, lat);
    @(negedge clk);
    check_result("t2", 1'b0, 15'h4000, 64'h8000_0000_0000_0000, 7'd0, 1'b0, 1'b0);
    drain("t2");

    // 3: zero mantissa
    send(1'b0, 15'h1234, 64'h0, lat);
    @(negedge clk);
    check_result("t3", 1'b0, 15'h0, 64'h0, 7'd0, 1'b1, 1'b0);
    drain("t3");

    // 4: exponent floor limits the shift
    send(1'b0, 15'h0010, 64'h0000_0000_00FF_0000, lat);
    @(negedge clk);
    check_result("t4", 1'b0, 15'h0, 64'h0000_00FF_0000_0000, 7'd16, 1'b0, 1'b1);
    drain("t4");

    // exp already zero: no shift, flagged denormal
    send(1'b1, 15'h0000, 64'h0000_0000_0000_1234, lat);
    @(negedge clk);
    check_result("t4b", 1'b1, 15'h0, 64'h0000_0000_0000_1234, 7'd0, 1'b0, 1'b1);
    drain("t4b");

    // 5: stalled output, second operand held upstream meanwhile
    send(1'b0, 15'h4000, 64'h0000_0001_0000_0000, lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_exp   = 15'h0100;
    bus.in_mant  = 64'h00F0_0000_0000_0000;
    held_mant = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5.vld%0d", i),  64'(bus.out_valid), 64'd1);
      check($sformatf("t5.rdy%0d", i),  64'(bus.in_ready),  64'd0);
      check($sformatf("t5.mant%0d", i), bus.out_mant,       held_mant);
      check($sformatf("t5.exp%0d", i),  64'(bus.out_exp),   64'h3FE1);
    end
    check_result("t5a", 1'b0, 15'h3FE1, held_mant, 7'd31, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5.vld_drop", 64'(bus.out_valid), 64'd0);
    check("t5.rdy_back", 64'(bus.in_ready),  64'd1);
    check("t5.keep",     bus.out_mant,       held_mant);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("t5.b_acc", 64'(bus.in_ready), 64'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("t5.b_lat", 64'(lat), 64'd3);
    @(negedge clk);
    check_result("t5b", 1'b1, 15'h00F8, 64'hF000_0000_0000_0000, 7'd8, 1'b0, 1'b0);
    drain("t5b");

    // 6: reset while in SHIFT
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b1;
    bus.in_exp   = 15'h2000;
    bus.in_mant  = 64'h0000_0000_0000_00FF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_result("t6r", 1'b0, 15'h0, 64'h0, 7'd0, 1'b0, 1'b0);
    check("t6r.vld", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6.rdy", 64'(bus.in_ready),  64'd1);
    check("t6.vld", 64'(bus.out_valid), 64'd0);
    send(1'b0, 15'h2000, 64'h0000_0000_0000_00FF, lat);
    check("t6.lat", 64'(lat), 64'd3);
    @(negedge clk);
    check_result("t6", 1'b0, 15'h1FC8, 64'hFF00_0000_0000_0000, 7'd56, 1'b0, 1'b0);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
